// File: rtl/bcd_down_timer_pkg.sv
// Shared definitions for the BCD down-timer: FSM encoding, BCD digit
// constants and the per-digit load clamp.
package bcd_down_timer_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_EXPIRED = 2'b10
  } state_e;

  // Digits above 9 are not BCD; pin them to 9.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_timer_digit.sv
// One mod-10 down-counting BCD digit with borrow chain.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   load          - capture load_digit (priority over decrement)
//   load_digit    - value to load (already sanitised)
//   borrow_in     - decrement request from the digit below (or enable)
//   digit         - registered digit value
//   borrow_out    - decrement request to the digit above
module bcd_down_digit
  import bcd_down_timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BCD_W-1:0] load_digit,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  // Next digit: load, else decrement with 0 -> 9 wrap, else hold.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_digit;
    end else if (borrow_in) begin
      digit_d = (digit_q == BCD_ZERO) ? BCD_MAX : digit_q - BCD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) digit_q <= BCD_ZERO;
    else     digit_q <= digit_d;
  end

  assign digit      = digit_q;
  assign borrow_out = borrow_in & (digit_q == BCD_ZERO);

endmodule

// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD down-timer with optional auto-reload.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   load       - capture load_val (clamped per digit) at the next edge
//   load_val   - BCD start value, digit 0 in [3:0]
//   en         - decrement enable while running
//   q          - registered BCD count
//   zero       - q is all zeros (decoded from the q register)
//   done       - registered one-cycle expiry pulse
//   busy       - state is RUN
module bcd_down_timer
  import bcd_down_timer_pkg::*;
#(
  parameter int unsigned DIGITS      = 2,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                en,
  output logic [4*DIGITS-1:0] q,
  output logic                zero,
  output logic                done,
  output logic                busy
);

  localparam int unsigned W = 4 * DIGITS;

  state_e         state_q, state_d;
  logic           done_q, done_d;
  logic [W-1:0]   reload_q;
  logic [W-1:0]   load_san;
  logic [W-1:0]   dig_data;
  logic           dig_load;
  logic           run;
  logic           expire;
  logic [DIGITS:0] borrow;
  logic           unused_top_borrow;

  // Per-digit clamp of the load value.
  always_comb begin
    load_san = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      load_san[BCD_W*i +: BCD_W] = bcd_clamp(load_val[BCD_W*i +: BCD_W]);
    end
  end

  assign run    = (state_q == ST_RUN);
  // Expiry: enabled decrement from exactly 1; a same-edge load overrides it.
  assign expire = run & en & ~load & (q == W'(1));

  // Digits load on an external load or on an auto-reload expiry.
  assign dig_load  = load | (AUTO_RELOAD & expire);
  assign dig_data  = load ? load_san : reload_q;
  assign borrow[0] = run & en & ~load;

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
    bcd_down_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .load       (dig_load),
      .load_digit (dig_data[BCD_W*g +: BCD_W]),
      .borrow_in  (borrow[g]),
      .digit      (q[BCD_W*g +: BCD_W]),
      .borrow_out (borrow[g+1])
    );
  end

  // Borrow out of the top digit cannot occur: expiry stops or reloads at 1.
  assign unused_top_borrow = borrow[DIGITS];

  // Next-state and done logic.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (load) begin
      state_d = (load_san == '0) ? ST_IDLE : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (expire) begin
            done_d  = 1'b1;
            state_d = AUTO_RELOAD ? ST_RUN : ST_EXPIRED;
          end
        end
        ST_IDLE, ST_EXPIRED: state_d = state_q;
        default:             state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Reload register follows every load, including a zero load.
  always_ff @(posedge clk) begin
    if (rst)       reload_q <= '0;
    else if (load) reload_q <= load_san;
  end

  assign done = done_q;
  assign busy = run;
  assign zero = (q == '0);

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: three instances (2 digits, 2 digits with
// auto-reload, 3 digits) checked every cycle against an integer model,
// plus literal expectations along the directed test sequence.
module tb_bcd_down_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        en = 1'b0;
  logic [11:0] lv = '0;

  logic [7:0]  q0, q1;
  logic [11:0] q2;
  logic        zero0, done0, busy0;
  logic        zero1, done1, busy1;
  logic        zero2, done2, busy2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_down_timer #(.DIGITS(2), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .load_val(lv[7:0]), .en(en),
    .q(q0), .zero(zero0), .done(done0), .busy(busy0));

  bcd_down_timer #(.DIGITS(2), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .load_val(lv[7:0]), .en(en),
    .q(q1), .zero(zero1), .done(done1), .busy(busy1));

  bcd_down_timer #(.DIGITS(3), .AUTO_RELOAD(1'b0)) dut2 (
    .clk(clk), .rst(rst), .load(load), .load_val(lv), .en(en),
    .q(q2), .zero(zero2), .done(done2), .busy(busy2));

  // Model: count kept as a plain integer; state 0 idle, 1 run, 2 expired.
  int m_val[3] = '{0, 0, 0};
  int m_rel[3] = '{0, 0, 0};
  int m_st[3]  = '{0, 0, 0};
  bit m_done[3] = '{0, 0, 0};
  int ndig[3]  = '{2, 2, 3};
  bit arel[3]  = '{1'b0, 1'b1, 1'b0};
  bit started  = 1'b0;

  function automatic int san(input logic [11:0] raw, input int nd);
    int v = 0;
    int p = 1;
    int d;
    for (int i = 0; i < nd; i++) begin
      d = int'(raw[4*i +: 4]);
      if (d > 9) d = 9;
      v += d * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r = '0;
    int t = v;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_val[i] = 0; m_rel[i] = 0; m_st[i] = 0; m_done[i] = 1'b0;
      end else begin
        m_done[i] = 1'b0;
        if (load) begin
          m_val[i] = san(lv, ndig[i]);
          m_rel[i] = m_val[i];
          m_st[i]  = (m_val[i] != 0) ? 1 : 0;
        end else if (m_st[i] == 1 && en) begin
          if (m_val[i] == 1) begin
            m_done[i] = 1'b1;
            if (arel[i]) m_val[i] = m_rel[i];
            else begin m_val[i] = 0; m_st[i] = 2; end
          end else begin
            m_val[i] = m_val[i] - 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("q0", {4'h0, q0}, to_bcd(m_val[0]));
      chk("q1", {4'h0, q1}, to_bcd(m_val[1]));
      chk("q2", q2, to_bcd(m_val[2]));
      chk("zero0", 12'(zero0), 12'(m_val[0] == 0));
      chk("zero1", 12'(zero1), 12'(m_val[1] == 0));
      chk("zero2", 12'(zero2), 12'(m_val[2] == 0));
      chk("done0", 12'(done0), 12'(m_done[0]));
      chk("done1", 12'(done1), 12'(m_done[1]));
      chk("done2", 12'(done2), 12'(m_done[2]));
      chk("busy0", 12'(busy0), 12'(m_st[0] == 1));
      chk("busy1", 12'(busy1), 12'(m_st[1] == 1));
      chk("busy2", 12'(busy2), 12'(m_st[2] == 1));
    end
  end

  task automatic step(input bit r, input bit l, input bit e, input logic [11:0] v);
    rst = r; load = l; en = e; lv = v;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] seq12 [13] = '{8'h12, 8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                              8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
  logic [7:0] seq_ar [7] = '{8'h03, 8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03};

  initial begin
    // Reset
    step(1, 0, 0, 12'h000);
    step(1, 1, 1, 12'h055);
    chk("rst_q0", {4'h0, q0}, 12'h000);
    chk("rst_zero0", 12'(zero0), 12'h1);
    chk("rst_busy0", 12'(busy0), 12'h0);
    chk("rst_done0", 12'(done0), 12'h0);

    // Count down from 12 to expiry
    step(0, 1, 0, 12'h012);
    chk("ld12_busy", 12'(busy0), 12'h1);
    for (int k = 0; k < 13; k++) begin
      chk("seq12_q0", {4'h0, q0}, {4'h0, seq12[k]});
      chk("seq12_done0", 12'(done0), (k == 12) ? 12'h1 : 12'h0);
      if (k < 12) step(0, 0, 1, 12'h000);
    end
    chk("exp_busy0", 12'(busy0), 12'h0);
    chk("ar12_q1", {4'h0, q1}, 12'h012);
    chk("ar12_done1", 12'(done1), 12'h1);
    step(0, 0, 1, 12'h000);
    step(0, 0, 1, 12'h000);
    chk("exp_hold_q0", {4'h0, q0}, 12'h000);
    chk("exp_hold_done0", 12'(done0), 12'h0);

    // Enable toggling
    step(0, 1, 0, 12'h003);
    step(0, 0, 1, 12'h000);
    chk("tog_a", {4'h0, q0}, 12'h002);
    step(0, 0, 0, 12'h000);
    step(0, 0, 0, 12'h000);
    chk("tog_b", {4'h0, q0}, 12'h002);
    step(0, 0, 1, 12'h000);
    chk("tog_c", {4'h0, q0}, 12'h001);
    chk("tog_done", 12'(done0), 12'h0);

    // Auto-reload period of 3
    step(0, 1, 0, 12'h003);
    for (int k = 0; k < 7; k++) begin
      chk("ar_q1", {4'h0, q1}, {4'h0, seq_ar[k]});
      chk("ar_done1", 12'(done1), (k == 3 || k == 6) ? 12'h1 : 12'h0);
      chk("ar_zero1", 12'(zero1), 12'h0);
      if (k < 6) step(0, 0, 1, 12'h000);
    end

    // Clamp and zero load
    step(0, 1, 0, 12'hFAF);
    chk("clamp_q0", {4'h0, q0}, 12'h099);
    chk("clamp_q2", q2, 12'h999);
    step(0, 1, 1, 12'h000);
    chk("zld_q0", {4'h0, q0}, 12'h000);
    chk("zld_zero0", 12'(zero0), 12'h1);
    chk("zld_busy0", 12'(busy0), 12'h0);
    chk("zld_done0", 12'(done0), 12'h0);
    step(0, 0, 1, 12'h000);

    // Load on the expiry edge wins
    step(0, 1, 0, 12'h002);
    step(0, 0, 1, 12'h000);
    chk("lx_pre", {4'h0, q0}, 12'h001);
    step(0, 1, 1, 12'h005);
    chk("lx_q0", {4'h0, q0}, 12'h005);
    chk("lx_done0", 12'(done0), 12'h0);
    chk("lx_busy0", 12'(busy0), 12'h1);

    // Full ripple borrow on 3 digits, and 10 -> 09
    step(0, 1, 0, 12'h100);
    step(0, 0, 1, 12'h000);
    chk("rip_q2", q2, 12'h099);
    step(0, 1, 0, 12'h010);
    step(0, 0, 1, 12'h000);
    chk("b10_q0", {4'h0, q0}, 12'h009);

    // Reset mid-count with load and en high
    step(0, 1, 0, 12'h047);
    chk("pre_rst_q0", {4'h0, q0}, 12'h047);
    step(1, 1, 1, 12'h055);
    chk("mrst_q0", {4'h0, q0}, 12'h000);
    chk("mrst_busy0", 12'(busy0), 12'h0);
    chk("mrst_done0", 12'(done0), 12'h0);
    step(0, 0, 1, 12'h000);
    chk("mrst_idle_q0", {4'h0, q0}, 12'h000);
    step(0, 0, 0, 12'h000);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_down_timer.md
# bcd_down_timer

Loadable multi-digit BCD down-counter and timer, the counting-down counterpart to the team's mod-10/mod-16 up counters. It is built from cascaded mod-10 down-digit stages with a borrow chain and loads a start value. It decrements once per enabled cycle, flags expiry with a one-cycle `done` pulse, and can optionally auto-reload for periodic ticks. It sits beside the up-counters as the timeout/countdown source for the tutorial designs.

## Interface
Parameters:
- `DIGITS`, default 2: number of BCD digits; the counter width is 4*DIGITS.
- `AUTO_RELOAD`, default 0: when 1, the block reloads the last loaded value on expiry instead of stopping.

Ports:
- `clk`, input, 1: single clock; all logic uses the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `load`, input, 1: capture `load_val` at the next edge.
- `load_val`, input, 4*DIGITS: BCD start value, digit 0 in bits [3:0].
- `en`, input, 1: decrement enable, one count per enabled edge.
- `q`, output, 4*DIGITS: current BCD count (registered).
- `zero`, output, 1: high when `q` is all zeros.
- `done`, output, 1: one-cycle expiry pulse (registered).
- `busy`, output, 1: high while in RUN.

## Operation
- States:
  - IDLE: no count loaded.
  - RUN: counting.
  - EXPIRED: reached zero with AUTO_RELOAD=0.
- Reset: `q`=0, `done`=0, state IDLE, so `busy`=0 and `zero`=1. The reload register is cleared.
- Load sanitising: any `load_val` digit greater than 9 is clamped to 9 per digit. The sanitised value goes to both `q` and the reload register.
- Load priority: `load` has priority over `en` in every state.
  - Sanitised value nonzero: next state RUN.
  - Sanitised value zero: next state IDLE, no `done`.
- RUN with `en`=1: BCD decrement.
  - Digit 0 decrements. A digit at 0 wraps to 9 and borrows from the next digit up.
  - Binary values 10–15 never appear in any digit.
- Expiry: the enabled RUN edge where `q`==1 (all upper digits 0, digit 0 = 1).
  - AUTO_RELOAD=0: `q` goes to 0, `done`=1 for one cycle, state goes to EXPIRED.
  - AUTO_RELOAD=1: `q` loads the reload register, `done`=1 for one cycle, state stays RUN. The period is exactly N enabled cycles for load value N.
- RUN with `en`=0: hold.
- IDLE and EXPIRED: `en` is ignored and `q` holds. Only `load` or `rst` leaves these states.
- `done` is cleared on every edge that is not an expiry edge.
- `busy` is high only in RUN. `zero` is decoded combinationally from the `q` register.

## Timing
- `load` sampled at edge k: `q` shows the sanitised value after edge k, and `busy` rises after edge k. Latency 1.
- From load value N (N≥1), expiry occurs on the N-th enabled edge after the load edge. `done` is high during the following cycle, aligned with `q`=0 (or with `q`=N on reload).
- Simultaneous `load` and expiry edge: the load wins, and `done` stays 0.
- `rst` mid-count: everything returns to reset values at that edge. A pending `load` or `en` in the same cycle is ignored.
- Wrap checks:
  - 10 → 09 borrows correctly.
  - 100 → 099 ripples the borrow through all digits in a single cycle.
  - No state ever wraps 00 → 99; expiry stops or reloads first.

## Structure
- The shared package holds:
  - The state encoding: IDLE=2'b00, RUN=2'b01, EXPIRED=2'b10.
  - The BCD digit constants BCD_MAX=4'd9 and BCD_ZERO=4'd0.
- Sub-module `bcd_down_digit`, instantiated DIGITS times in a generate chain:
  - Inputs: `clk`, `rst`, `load`, `load_digit`, `borrow_in`.
  - Outputs: `digit`, `borrow_out`.
  - `borrow_out` = `borrow_in` & (`digit`==0).
  - Digit 0 receives `borrow_in` = RUN & `en` & ~`load`.
- The top level holds the FSM, the reload register, the expiry detect (`q`==1 & decrement enabled) and the `done` register.

## Test plan
- Reset then `load_val`=8'h12, `load`=1, then `en`=1: `q` sequence 12, 11, 10, 09 … 01, 00. `done`=1 only in the cycle `q`=00 first appears (12 enabled edges after the load edge). State EXPIRED, `busy`=0, then `q` holds at 00 under continued `en`.
- `en` toggled 1,0,0,1 after loading 8'h03: `q` goes 03→02, holds 02, 02, then →01. No `done` yet.
- AUTO_RELOAD=1, load 8'h03, `en` held: `q` sequence 03, 02, 01, 03, 02, 01, 03. `done` pulses each time `q` returns to 03, and `zero` is never 1.
- `load_val`=8'hAF: `q`=8'h99. `load_val`=8'h00: state IDLE, `zero`=1, `done`=0.
- `load` asserted on the expiry edge (`q`=01, `en`=1, `load_val`=8'h05): `q`=05, `done`=0, `busy`=1.
- `rst`=1 mid-count at `q`=8'h47 with `load` and `en` also high: the next cycle shows `q`=00, `busy`=0, `done`=0, state IDLE.
